// File: rtl/mux_arbiter_if.sv
// rtl/mux_arbiter_if.sv - requester/consumer bundle for the round-robin mux arbiter
interface mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] A3;
    logic             ready;
    logic [WIDTH-1:0] Y;
    logic             valid;
    logic [1:0]       S;
    logic [3:0]       gnt;
    logic [3:0]       ack;

    modport master (
        output req, A0, A1, A2, A3, ready,
        input  Y, valid, S, gnt, ack
    );

    modport slave (
        input  req, A0, A1, A2, A3, ready,
        output Y, valid, S, gnt, ack
    );
endinterface

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - 4-way round-robin arbiter muxing one registered word per grant
module mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_arbiter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       last;
    logic [3:0]       pool;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       cand;
    logic [WIDTH-1:0] win_data;

    // The requester being acknowledged is masked so it cannot win twice in a row.
    always_comb begin
        pool  = (state == BUSY) ? (bus.req & ~bus.gnt) : bus.req;
        found = 1'b0;
        win   = last;
        cand  = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && pool[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        case (win)
            2'd0:    win_data = bus.A0;
            2'd1:    win_data = bus.A1;
            2'd2:    win_data = bus.A2;
            default: win_data = bus.A3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus.Y     <= '0;
            bus.S     <= 2'd0;
            bus.gnt   <= 4'b0000;
            bus.valid <= 1'b0;
            last      <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        bus.Y     <= win_data;
                        bus.S     <= win;
                        bus.gnt   <= 4'b0001 << win;
                        bus.valid <= 1'b1;
                        last      <= win;
                    end
                end
                BUSY: begin
                    if (bus.ready) begin
                        if (found) begin
                            bus.Y   <= win_data;
                            bus.S   <= win;
                            bus.gnt <= 4'b0001 << win;
                            last    <= win;
                        end else begin
                            state     <= IDLE;
                            bus.gnt   <= 4'b0000;
                            bus.valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A word caught by reset is dropped, so it is never acknowledged.
    assign bus.ack = (bus.valid && bus.ready && !rst) ? bus.gnt : 4'b0000;
endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - vector, sequence and randomized checks for mux_arbiter
module tb_mux_arbiter;
    logic clk;
    logic rst;

    mux_arbiter_if #(.WIDTH(8)) bus ();

    mux_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       m_known = 1'b0;
    logic       m_valid;
    logic [7:0] m_y;
    int         m_s;
    int         m_last;
    int         wait_cnt [4];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ready;
        logic [7:0] a2;
        logic [3:0] exp_ack;
        logic       exp_valid;
        logic [7:0] exp_y;
        logic [1:0] exp_s;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] pool, input int from);
        for (int k = 1; k <= 4; k++)
            if (pool[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        return m_valid ? 4'(1 << m_s) : 4'b0000;
    endfunction

    // One clock: drive, check model before the edge, advance model, sample after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic rd,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3,
                        output logic [3:0] ack_seen);
        logic [7:0] a [4];
        logic       pre_valid;
        logic [3:0] pool;
        int         w;
        int         worst;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        rst = r; bus.req = rq; bus.ready = rd;
        bus.A0 = a0; bus.A1 = a1; bus.A2 = a2; bus.A3 = a3;
        @(negedge clk);
        ack_seen  = bus.ack;
        pre_valid = bus.valid;
        chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
        chk("ack_onehot", 32'($countones(bus.ack) <= 1), 32'd1);
        if (m_known) begin
            chk("model_ack", 32'(bus.ack), 32'((!r && m_valid && rd) ? m_gnt() : 4'b0000));
            chk("model_valid", 32'(bus.valid), 32'(m_valid));
            chk("model_y", 32'(bus.Y), 32'(m_y));
            chk("model_s", 32'(bus.S), 32'(m_s));
            chk("model_gnt", 32'(bus.gnt), 32'(m_gnt()));
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_known = 1'b1; m_valid = 1'b0; m_y = 8'h00; m_s = 0; m_last = 3;
            for (int j = 0; j < 4; j++) wait_cnt[j] = 0;
        end else if (m_known && (!m_valid || rd)) begin
            pool = m_valid ? (rq & ~m_gnt()) : rq;
            w = rr_pick(pool, m_last);
            if (w >= 0) begin
                m_valid = 1'b1; m_y = a[w]; m_s = w; m_last = w;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (!r) begin
            if (bus.valid && (!pre_valid || ack_seen != 4'b0000)) begin
                worst = 0;
                for (int j = 0; j < 4; j++) begin
                    if (j == int'(bus.S)) wait_cnt[j] = 0;
                    else if (rq[j]) wait_cnt[j]++;
                    if (wait_cnt[j] > worst) worst = wait_cnt[j];
                end
                chk("starve_bound", 32'(worst <= 4), 32'd1);
            end
            for (int j = 0; j < 4; j++)
                if (!rq[j]) wait_cnt[j] = 0;
        end
    endtask

    logic [3:0] ack_v;

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 8'h32, 4'b0000, 1'b0, 8'h00, 2'd0, 4'b0000};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 8'h32, 4'b0000, 1'b1, 8'h10, 2'd0, 4'b0001};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 8'h32, 4'b0001, 1'b1, 8'h21, 2'd1, 4'b0010};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 8'h32, 4'b0010, 1'b1, 8'h32, 2'd2, 4'b0100};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 8'h32, 4'b0100, 1'b1, 8'h43, 2'd3, 4'b1000};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, 8'h32, 4'b1000, 1'b1, 8'h10, 2'd0, 4'b0001};
        tbl[6]  = '{1'b1, 4'h4, 1'b0, 8'hAA, 4'b0000, 1'b0, 8'h00, 2'd0, 4'b0000};
        tbl[7]  = '{1'b0, 4'h4, 1'b0, 8'hAA, 4'b0000, 1'b1, 8'hAA, 2'd2, 4'b0100};
        tbl[8]  = '{1'b0, 4'h4, 1'b0, 8'hAA, 4'b0000, 1'b1, 8'hAA, 2'd2, 4'b0100};
        tbl[9]  = '{1'b0, 4'h4, 1'b0, 8'hAA, 4'b0000, 1'b1, 8'hAA, 2'd2, 4'b0100};
        tbl[10] = '{1'b0, 4'h4, 1'b0, 8'h55, 4'b0000, 1'b1, 8'hAA, 2'd2, 4'b0100};
        tbl[11] = '{1'b0, 4'h4, 1'b1, 8'h55, 4'b0100, 1'b0, 8'hAA, 2'd2, 4'b0000};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 8'h55, 4'b0000, 1'b0, 8'hAA, 2'd2, 4'b0000};

        rst = 1'b1; bus.req = 4'h0; bus.ready = 1'b0;
        bus.A0 = 8'h00; bus.A1 = 8'h00; bus.A2 = 8'h00; bus.A3 = 8'h00;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].ready, 8'h10, 8'h21, tbl[i].a2, 8'h43, ack_v);
            chk($sformatf("vec%0d_ack", i), 32'(ack_v), 32'(tbl[i].exp_ack));
            chk($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_y", i), 32'(bus.Y), 32'(tbl[i].exp_y));
            chk($sformatf("vec%0d_s", i), 32'(bus.S), 32'(tbl[i].exp_s));
            chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].exp_gnt));
        end

        // Lone requester with ready held: no self back-to-back.
        step(1'b1, 4'h0, 1'b0, 8'h10, 8'h21, 8'h32, 8'h43, ack_v);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b0010, 1'b1, 8'h10, 8'h21, 8'h32, 8'h43, ack_v);
            chk("solo_valid", 32'(bus.valid), 32'((k % 2) == 0));
            if (bus.valid) chk("solo_s", 32'(bus.S), 32'd1);
        end

        // Reset in the middle of a stalled transfer.
        step(1'b1, 4'h0, 1'b0, 8'h10, 8'h21, 8'h32, 8'h43, ack_v);
        step(1'b0, 4'b1000, 1'b0, 8'h10, 8'h21, 8'h32, 8'h43, ack_v);
        chk("midrst_s3", 32'(bus.S), 32'd3);
        chk("midrst_valid", 32'(bus.valid), 32'd1);
        step(1'b1, 4'b1000, 1'b0, 8'h10, 8'h21, 8'h32, 8'h43, ack_v);
        chk("midrst_ack_in_rst", 32'(ack_v), 32'd0);
        chk("midrst_valid0", 32'(bus.valid), 32'd0);
        chk("midrst_y0", 32'(bus.Y), 32'd0);
        chk("midrst_gnt0", 32'(bus.gnt), 32'd0);
        step(1'b0, 4'b1001, 1'b0, 8'h10, 8'h21, 8'h32, 8'h43, ack_v);
        chk("midrst_ack_after", 32'(ack_v), 32'd0);
        chk("midrst_s0", 32'(bus.S), 32'd0);
        chk("midrst_gnt1", 32'(bus.gnt), 32'b0001);
        chk("midrst_y10", 32'(bus.Y), 32'h10);

        // Drain, then ready with nothing pending must be inert.
        step(1'b0, 4'h0, 1'b1, 8'h10, 8'h21, 8'h32, 8'h43, ack_v);
        chk("drain_ack", 32'(ack_v), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'h0, 1'b1, 8'h77, 8'h66, 8'h55, 8'h44, ack_v);
            chk("idle_ack", 32'(ack_v), 32'd0);
            chk("idle_valid", 32'(bus.valid), 32'd0);
            chk("idle_y", 32'(bus.Y), 32'h10);
            chk("idle_s", 32'(bus.S), 32'd0);
            chk("idle_gnt", 32'(bus.gnt), 32'd0);
        end

        for (int n = 0; n < 10000; n++) begin
            step(($urandom % 500) == 0, 4'($urandom_range(0, 15)), ($urandom % 4) != 0,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), ack_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, data width of each requester input and of Y.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: req  input  4  request per requester; bit i belongs to Ai.
REQ-005 Port: A0, A1, A2, A3  input  WIDTH each  requester data words.
REQ-006 Port: ready  input  1  downstream consumer accepts Y this cycle.
REQ-007 Port: Y  output  WIDTH  registered data word of the granted requester.
REQ-008 Port: valid  output  1  Y holds a word awaiting acceptance.
REQ-009 Port: S  output  2  registered index of the current or last granted requester.
REQ-010 Port: gnt  output  4  one-hot current grant; all zero when valid=0.
REQ-011 Port: ack  output  4  combinational; ack[i] = valid & ready & gnt[i].

Function
REQ-012 FSM SHALL have two states: IDLE (valid=0) and BUSY (valid=1).
REQ-013 Arbitration SHALL be round-robin: search order begins at (last+1) mod 4 and wraps; last = index of the most recent grant.
REQ-014 IDLE, any req bit set: on the next edge, the winner i SHALL be captured: Y<=Ai, S<=i, gnt<=onehot(i), last<=i, valid<=1, state->BUSY (1-cycle req-to-valid latency).
REQ-015 IDLE, req=0: all outputs and last SHALL hold; Y keeps its previous value.
REQ-016 BUSY, ready=0: Y, S, gnt, valid SHALL hold unchanged, regardless of changes on req or A0..A3.
REQ-017 BUSY, ready=1: the transfer completes this cycle and ack[S] SHALL be 1 for exactly this cycle.
REQ-018 BUSY, ready=1: arbitration SHALL run over req & ~gnt; a winner is captured on the same edge per REQ-014 and state stays BUSY (back-to-back, one word per cycle).
REQ-019 BUSY, ready=1, req & ~gnt = 0: next state IDLE, valid<=0, gnt<=0; S and Y hold.
REQ-020 A requester whose req is still high after its own ack SHALL be re-granted only via a later arbitration; it can never win twice in a row while another requester is pending.
REQ-021 Data SHALL be captured at grant time; a requester dropping req or changing Ai after grant SHALL NOT affect the pending Y.
REQ-022 ready while valid=0 SHALL have no effect; ack SHALL stay 0.
REQ-023 gnt SHALL always be zero or one-hot; ack SHALL always be zero or one-hot.
REQ-024 Starvation bound: a requester holding req high SHALL be granted within 4 grants.

Reset
REQ-025 rst=1 at an edge SHALL force: state IDLE, Y=0, S=0, gnt=0, valid=0, last=3 (first priority to requester 0).
REQ-026 rst SHALL override all other inputs, including mid-BUSY; the pending word is discarded and no ack is issued in the reset cycle or after it.
REQ-027 First arbitration SHALL occur on the first edge with rst=0 and req nonzero.

Verification
REQ-028 After reset, req=4'b1111, A0..A3=8'h10,8'h21,8'h32,8'h43, ready=1 held -> grants 0,1,2,3,0 on consecutive cycles; Y=10,21,32,43,10; valid stays 1.
REQ-029 req=4'b0100, A2=8'hAA, ready=0 for 3 cycles, then A2=8'h55, then ready=1 -> Y=AA, S=2, gnt=0100 held; ack=0100 for one cycle; then IDLE, valid=0.
REQ-030 Only req[1] high, ready=1 continuous -> valid alternates 1,0,1,0 (no self back-to-back); every grant has S=1.
REQ-031 BUSY with S=3 and ready=0, assert rst for 1 cycle -> next cycle valid=0, Y=0, gnt=0, ack=0; with req=4'b1001 the next grant goes to 0.
REQ-032 ready=1 with valid=0 and req=0 for 5 cycles -> ack=0, all outputs constant.
REQ-033 Random req/ready for 10k cycles -> gnt and ack always zero or one-hot; Y always equals the Ai sampled at its grant; no pending requester waits more than 4 grants.
